axis_bus_demux: RTL and testbench

//  1:8 AXI-Stream packet router; the counterpart of the 8:1 bus mux.
//  - Takes one 32-bit AXIS stream and steers each whole packet to one of 8 output streams.
//  - Uses the same bus_sel encoding as the mux: 8'd128+n selects output n.
//  - Destination is latched on the first beat of a packet and held until tlast.
//  - One registered output slice with full tvalid/tready backpressure.

---
 rtl/axis_bus_demux.sv | 267 ++++++++++++++++++++++++++
 tb/tb_axis_bus_demux.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_bus_demux.sv
// 1:8 AXI-Stream packet router: each packet is steered whole to the output chosen by bus_sel on its first beat.
// Optional macro AXIS_DEMUX_DROP_EN discards packets with an invalid bus_sel and counts them on drop_cnt.
//
// state | meaning
// IDLE  | waiting for the first beat of a packet
// ROUTE | forwarding beats of the current packet to r_dest
// DROP  | discarding beats of a packet with invalid bus_sel (AXIS_DEMUX_DROP_EN only)
module axis_bus_demux #(
  parameter logic [7:0] CHOOSE_FIFO_BASE = 8'd128,
  parameter int         DATA_W           = 32
) (
  input  logic                axis_aclk,
  input  logic                axis_aresetn,
  input  logic [7:0]          bus_sel,

  input  logic                axis_in_tvalid,
  output logic                axis_in_tready,
  input  logic [DATA_W-1:0]   axis_in_tdata,
  input  logic [DATA_W/8-1:0] axis_in_tkeep,
  input  logic                axis_in_tlast,

  output logic                axis_out_0_tvalid,
  input  logic                axis_out_0_tready,
  output logic [DATA_W-1:0]   axis_out_0_tdata,
  output logic [DATA_W/8-1:0] axis_out_0_tkeep,
  output logic                axis_out_0_tlast,

  output logic                axis_out_1_tvalid,
  input  logic                axis_out_1_tready,
  output logic [DATA_W-1:0]   axis_out_1_tdata,
  output logic [DATA_W/8-1:0] axis_out_1_tkeep,
  output logic                axis_out_1_tlast,

  output logic                axis_out_2_tvalid,
  input  logic                axis_out_2_tready,
  output logic [DATA_W-1:0]   axis_out_2_tdata,
  output logic [DATA_W/8-1:0] axis_out_2_tkeep,
  output logic                axis_out_2_tlast,

  output logic                axis_out_3_tvalid,
  input  logic                axis_out_3_tready,
  output logic [DATA_W-1:0]   axis_out_3_tdata,
  output logic [DATA_W/8-1:0] axis_out_3_tkeep,
  output logic                axis_out_3_tlast,

  output logic                axis_out_4_tvalid,
  input  logic                axis_out_4_tready,
  output logic [DATA_W-1:0]   axis_out_4_tdata,
  output logic [DATA_W/8-1:0] axis_out_4_tkeep,
  output logic                axis_out_4_tlast,

  output logic                axis_out_5_tvalid,
  input  logic                axis_out_5_tready,
  output logic [DATA_W-1:0]   axis_out_5_tdata,
  output logic [DATA_W/8-1:0] axis_out_5_tkeep,
  output logic                axis_out_5_tlast,

  output logic                axis_out_6_tvalid,
  input  logic                axis_out_6_tready,
  output logic [DATA_W-1:0]   axis_out_6_tdata,
  output logic [DATA_W/8-1:0] axis_out_6_tkeep,
  output logic                axis_out_6_tlast,

  output logic                axis_out_7_tvalid,
  input  logic                axis_out_7_tready,
  output logic [DATA_W-1:0]   axis_out_7_tdata,
  output logic [DATA_W/8-1:0] axis_out_7_tkeep,
  output logic                axis_out_7_tlast,

  output logic                busy
`ifdef AXIS_DEMUX_DROP_EN
  ,
  output logic [15:0]         drop_cnt
`endif
);

  localparam int KEEP_W = DATA_W / 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUTE = 2'd1;
`ifdef AXIS_DEMUX_DROP_EN
  localparam logic [1:0] S_DROP  = 2'd2;
`endif

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [2:0]        r_dest;
  logic              r_sv;
  logic [DATA_W-1:0] r_data;
  logic [KEEP_W-1:0] r_keep;
  logic              r_last;

  logic [7:0]        w_sel_off;
  logic              w_sel_ok;
  logic [7:0]        w_out_tready;
  logic [7:0]        w_out_tvalid;
  logic              w_dest_ready;
  logic              w_free;
  logic              w_in_tready;
  logic              w_load;
  logic              w_first;
`ifdef AXIS_DEMUX_DROP_EN
  logic              w_discard;
  logic [15:0]       r_drop_cnt;
`endif

  // Codes below the base wrap to large values, so one compare rejects both sides of the window.
  assign w_sel_off = bus_sel - CHOOSE_FIFO_BASE;
  assign w_sel_ok  = (w_sel_off < 8'd8);

  assign w_out_tready = {axis_out_7_tready, axis_out_6_tready, axis_out_5_tready, axis_out_4_tready,
                         axis_out_3_tready, axis_out_2_tready, axis_out_1_tready, axis_out_0_tready};

  assign w_dest_ready = w_out_tready[r_dest];
  // The slice can take a beat if it is empty or its current beat leaves this cycle.
  assign w_free       = !r_sv || w_dest_ready;

  always_comb begin
    w_in_tready = 1'b0;
    w_load      = 1'b0;
    w_first     = 1'b0;
`ifdef AXIS_DEMUX_DROP_EN
    w_discard   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_sel_ok) begin
          w_in_tready = w_free;
          w_load      = axis_in_tvalid && w_free;
          w_first     = 1'b1;
        end else begin
`ifdef AXIS_DEMUX_DROP_EN
          w_in_tready = 1'b1;
          w_discard   = axis_in_tvalid;
`endif
        end
      end
      S_ROUTE: begin
        w_in_tready = w_free;
        w_load      = axis_in_tvalid && w_free;
      end
`ifdef AXIS_DEMUX_DROP_EN
      S_DROP: begin
        w_in_tready = 1'b1;
        w_discard   = axis_in_tvalid;
      end
`endif
      default: begin
        w_in_tready = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_load && !axis_in_tlast) begin
          w_state_nxt = S_ROUTE;
        end
`ifdef AXIS_DEMUX_DROP_EN
        if (w_discard && !axis_in_tlast) begin
          w_state_nxt = S_DROP;
        end
`endif
      end
      S_ROUTE: begin
        if (w_load && axis_in_tlast) begin
          w_state_nxt = S_IDLE;
        end
      end
`ifdef AXIS_DEMUX_DROP_EN
      S_DROP: begin
        if (w_discard && axis_in_tlast) begin
          w_state_nxt = S_IDLE;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      r_state <= S_IDLE;
      r_dest  <= 3'd0;
      r_sv    <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_sv   <= 1'b1;
        r_data <= axis_in_tdata;
        r_keep <= axis_in_tkeep;
        r_last <= axis_in_tlast;
        // Only a first beat retargets; w_free guarantees no pending beat is redirected.
        if (w_first) begin
          r_dest <= w_sel_off[2:0];
        end
      end else if (r_sv && w_dest_ready) begin
        r_sv <= 1'b0;
      end
    end
  end

`ifdef AXIS_DEMUX_DROP_EN
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      r_drop_cnt <= 16'd0;
    end else if (w_discard && axis_in_tlast && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_out_tvalid[i] = r_sv && (r_dest == 3'(i));
    end
  end

  assign axis_in_tready = w_in_tready;
  assign busy           = (r_state != S_IDLE) || r_sv;

  assign axis_out_0_tvalid = w_out_tvalid[0];
  assign axis_out_1_tvalid = w_out_tvalid[1];
  assign axis_out_2_tvalid = w_out_tvalid[2];
  assign axis_out_3_tvalid = w_out_tvalid[3];
  assign axis_out_4_tvalid = w_out_tvalid[4];
  assign axis_out_5_tvalid = w_out_tvalid[5];
  assign axis_out_6_tvalid = w_out_tvalid[6];
  assign axis_out_7_tvalid = w_out_tvalid[7];

  assign axis_out_0_tdata = r_data;
  assign axis_out_1_tdata = r_data;
  assign axis_out_2_tdata = r_data;
  assign axis_out_3_tdata = r_data;
  assign axis_out_4_tdata = r_data;
  assign axis_out_5_tdata = r_data;
  assign axis_out_6_tdata = r_data;
  assign axis_out_7_tdata = r_data;

  assign axis_out_0_tkeep = r_keep;
  assign axis_out_1_tkeep = r_keep;
  assign axis_out_2_tkeep = r_keep;
  assign axis_out_3_tkeep = r_keep;
  assign axis_out_4_tkeep = r_keep;
  assign axis_out_5_tkeep = r_keep;
  assign axis_out_6_tkeep = r_keep;
  assign axis_out_7_tkeep = r_keep;

  assign axis_out_0_tlast = r_last;
  assign axis_out_1_tlast = r_last;
  assign axis_out_2_tlast = r_last;
  assign axis_out_3_tlast = r_last;
  assign axis_out_4_tlast = r_last;
  assign axis_out_5_tlast = r_last;
  assign axis_out_6_tlast = r_last;
  assign axis_out_7_tlast = r_last;

endmodule

// File: tb/tb_axis_bus_demux.sv
// Directed bench for axis_bus_demux: routing, sel hold, backpressure, back-to-back, invalid sel, reset.
`timescale 1ns/1ps
module tb_axis_bus_demux;

  logic        clk;
  logic        rstn;
  logic [7:0]  bus_sel;
  logic        in_tvalid;
  logic        in_tready;
  logic [31:0] in_tdata;
  logic [3:0]  in_tkeep;
  logic        in_tlast;
  logic [7:0]  out_tvalid;
  logic [7:0]  out_tready;
  logic [31:0] out_tdata [8];
  logic [3:0]  out_tkeep [8];
  logic [7:0]  out_tlast;
  logic        busy;
`ifdef AXIS_DEMUX_DROP_EN
  logic [15:0] drop_cnt;
`endif

  typedef struct {
    int          port;
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    int          cyc;
  } beat_t;

  beat_t mon_q[$];
  int    vcnt [8];
  int    cyc;
  int    acc_cyc;
  int    n_checks;
  int    n_fail;

  axis_bus_demux dut (
    .axis_aclk(clk), .axis_aresetn(rstn), .bus_sel(bus_sel),
    .axis_in_tvalid(in_tvalid), .axis_in_tready(in_tready), .axis_in_tdata(in_tdata),
    .axis_in_tkeep(in_tkeep), .axis_in_tlast(in_tlast),
    .axis_out_0_tvalid(out_tvalid[0]), .axis_out_0_tready(out_tready[0]), .axis_out_0_tdata(out_tdata[0]), .axis_out_0_tkeep(out_tkeep[0]), .axis_out_0_tlast(out_tlast[0]),
    .axis_out_1_tvalid(out_tvalid[1]), .axis_out_1_tready(out_tready[1]), .axis_out_1_tdata(out_tdata[1]), .axis_out_1_tkeep(out_tkeep[1]), .axis_out_1_tlast(out_tlast[1]),
    .axis_out_2_tvalid(out_tvalid[2]), .axis_out_2_tready(out_tready[2]), .axis_out_2_tdata(out_tdata[2]), .axis_out_2_tkeep(out_tkeep[2]), .axis_out_2_tlast(out_tlast[2]),
    .axis_out_3_tvalid(out_tvalid[3]), .axis_out_3_tready(out_tready[3]), .axis_out_3_tdata(out_tdata[3]), .axis_out_3_tkeep(out_tkeep[3]), .axis_out_3_tlast(out_tlast[3]),
    .axis_out_4_tvalid(out_tvalid[4]), .axis_out_4_tready(out_tready[4]), .axis_out_4_tdata(out_tdata[4]), .axis_out_4_tkeep(out_tkeep[4]), .axis_out_4_tlast(out_tlast[4]),
    .axis_out_5_tvalid(out_tvalid[5]), .axis_out_5_tready(out_tready[5]), .axis_out_5_tdata(out_tdata[5]), .axis_out_5_tkeep(out_tkeep[5]), .axis_out_5_tlast(out_tlast[5]),
    .axis_out_6_tvalid(out_tvalid[6]), .axis_out_6_tready(out_tready[6]), .axis_out_6_tdata(out_tdata[6]), .axis_out_6_tkeep(out_tkeep[6]), .axis_out_6_tlast(out_tlast[6]),
    .axis_out_7_tvalid(out_tvalid[7]), .axis_out_7_tready(out_tready[7]), .axis_out_7_tdata(out_tdata[7]), .axis_out_7_tkeep(out_tkeep[7]), .axis_out_7_tlast(out_tlast[7]),
    .busy(busy)
`ifdef AXIS_DEMUX_DROP_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Handshakes seen at the negedge complete at the following posedge (number cyc+1).
  initial begin
    forever begin
      @(negedge clk);
      for (int n = 0; n < 8; n++) begin
        if (out_tvalid[n] === 1'b1) begin
          vcnt[n] = vcnt[n] + 1;
          if (out_tready[n] === 1'b1)
            mon_q.push_back('{port: n, data: out_tdata[n], keep: out_tkeep[n], last: out_tlast[n], cyc: cyc + 1});
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    mon_q.delete();
    for (int n = 0; n < 8; n++) vcnt[n] = 0;
  endtask

  task automatic in_idle();
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic drain(input int n);
    in_idle();
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [7:0] sel, input logic [31:0] d, input logic [3:0] k, input logic l);
    int  waited;
    bit  done;
    waited    = 0;
    done      = 1'b0;
    bus_sel   = sel;
    in_tvalid = 1'b1;
    in_tdata  = d;
    in_tkeep  = k;
    in_tlast  = l;
    while (!done && waited < 40) begin
      @(negedge clk);
      if (in_tready === 1'b1) begin
        done    = 1'b1;
        acc_cyc = cyc + 1;
      end
      @(posedge clk);
      #1;
      waited++;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL drive_timeout: beat %h not accepted, waited %0d cycles, required acceptance within 40", d, waited);
    end
  endtask

  task automatic test_reset();
    rstn       = 1'b0;
    bus_sel    = 8'd0;
    in_idle();
    in_tdata   = 32'hFFFF_FFFF;
    in_tkeep   = 4'hF;
    out_tready = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_tvalid !== 8'h00) begin n_fail++; $display("FAIL reset_tvalid: got %b, required 00000000", out_tvalid); end
    for (int n = 0; n < 8; n++) begin
      n_checks++;
      if (out_tdata[n] !== 32'h0 || out_tkeep[n] !== 4'h0 || out_tlast[n] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_payload[%0d]: got %h/%h/%b, required 0/0/0", n, out_tdata[n], out_tkeep[n], out_tlast[n]);
      end
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
`ifdef AXIS_DEMUX_DROP_EN
    n_checks++;
    if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d, required 0", drop_cnt); end
    n_checks++;
    if (in_tready !== 1'b1) begin n_fail++; $display("FAIL reset_tready_badsel: got %b, required 1", in_tready); end
`else
    n_checks++;
    if (in_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready_badsel: got %b, required 0", in_tready); end
`endif
    @(posedge clk);
    #1;
    rstn = 1'b1;
    drain(2);
  endtask

  task automatic test_route_basic();
    logic [31:0] exp_d [4];
    logic [3:0]  exp_k [4];
    int          a0;
    exp_d = '{32'hD000_0000, 32'hD111_1111, 32'hD222_2222, 32'hD333_3333};
    exp_k = '{4'hF, 4'hF, 4'hF, 4'h3};
    out_tready = 8'hFF;
    clear_mon();
    a0 = 0;
    for (int i = 0; i < 4; i++) begin
      drive_beat(8'd131, exp_d[i], exp_k[i], i == 3);
      if (i == 0) a0 = acc_cyc;
    end
    drain(4);
    n_checks++;
    if (mon_q.size() != 4) begin n_fail++; $display("FAIL route_count: got %0d beats, required 4", mon_q.size()); end
    for (int i = 0; i < mon_q.size() && i < 4; i++) begin
      n_checks++;
      if (mon_q[i].port != 3 || mon_q[i].data !== exp_d[i] || mon_q[i].keep !== exp_k[i] ||
          mon_q[i].last !== (i == 3) || mon_q[i].cyc != a0 + 1 + i) begin
        n_fail++;
        $display("FAIL route_beat[%0d]: got port %0d data %h keep %h last %b cyc %0d, required port 3 data %h keep %h last %b cyc %0d",
                 i, mon_q[i].port, mon_q[i].data, mon_q[i].keep, mon_q[i].last, mon_q[i].cyc,
                 exp_d[i], exp_k[i], (i == 3), a0 + 1 + i);
      end
    end
    for (int n = 0; n < 8; n++) begin
      n_checks++;
      if (vcnt[n] != ((n == 3) ? 4 : 0)) begin
        n_fail++;
        $display("FAIL route_valid_cycles[%0d]: got %0d, required %0d", n, vcnt[n], (n == 3) ? 4 : 0);
      end
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL route_busy_after: got %b, required 0", busy); end
  endtask

  task automatic test_sel_hold();
    logic [31:0] exp_d [3];
    exp_d = '{32'hA5A5_0000, 32'hA5A5_0001, 32'hA5A5_0002};
    out_tready = 8'hFF;
    clear_mon();
    drive_beat(8'd128, exp_d[0], 4'hF, 1'b0);
    drive_beat(8'd135, exp_d[1], 4'hF, 1'b0);
    drive_beat(8'd135, exp_d[2], 4'hF, 1'b1);
    drain(4);
    n_checks++;
    if (mon_q.size() != 3) begin n_fail++; $display("FAIL selhold_count: got %0d beats, required 3", mon_q.size()); end
    for (int i = 0; i < mon_q.size() && i < 3; i++) begin
      n_checks++;
      if (mon_q[i].port != 0 || mon_q[i].data !== exp_d[i]) begin
        n_fail++;
        $display("FAIL selhold_beat[%0d]: got port %0d data %h, required port 0 data %h", i, mon_q[i].port, mon_q[i].data, exp_d[i]);
      end
    end
    n_checks++;
    if (vcnt[7] != 0) begin n_fail++; $display("FAIL selhold_out7: got %0d valid cycles, required 0", vcnt[7]); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_d [4];
    exp_d = '{32'hB000_0010, 32'hB000_0011, 32'hB000_0012, 32'hB000_0013};
    out_tready = 8'hFF;
    clear_mon();
    drive_beat(8'd130, exp_d[0], 4'hF, 1'b0);
    drive_beat(8'd130, exp_d[1], 4'hF, 1'b0);
    out_tready[2] = 1'b0;
    in_tvalid = 1'b1;
    in_tdata  = exp_d[2];
    in_tlast  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (in_tready !== 1'b0 || out_tvalid[2] !== 1'b1 || out_tdata[2] !== exp_d[1]) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got in_tready %b valid %b data %h, required 0 1 %h", c, in_tready, out_tvalid[2], out_tdata[2], exp_d[1]);
      end
      @(posedge clk);
      #1;
    end
    out_tready[2] = 1'b1;
    drive_beat(8'd130, exp_d[2], 4'hF, 1'b0);
    drive_beat(8'd130, exp_d[3], 4'hF, 1'b1);
    drain(4);
    n_checks++;
    if (mon_q.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d beats, required 4", mon_q.size()); end
    for (int i = 0; i < mon_q.size() && i < 4; i++) begin
      n_checks++;
      if (mon_q[i].port != 2 || mon_q[i].data !== exp_d[i] || mon_q[i].last !== (i == 3)) begin
        n_fail++;
        $display("FAIL bp_beat[%0d]: got port %0d data %h last %b, required port 2 data %h last %b",
                 i, mon_q[i].port, mon_q[i].data, mon_q[i].last, exp_d[i], (i == 3));
      end
    end
  endtask

  task automatic test_back_to_back();
    int a0;
    int a1;
    int a2;
    out_tready = 8'hFF;
    clear_mon();
    drive_beat(8'd129, 32'hC100_0000, 4'hF, 1'b1);
    a0 = acc_cyc;
    drive_beat(8'd134, 32'hC600_0000, 4'hF, 1'b0);
    a1 = acc_cyc;
    drive_beat(8'd134, 32'hC600_0001, 4'hF, 1'b1);
    a2 = acc_cyc;
    drain(4);
    n_checks++;
    if (a1 != a0 + 1 || a2 != a1 + 1) begin
      n_fail++;
      $display("FAIL b2b_input_bubble: got accept cycles %0d %0d %0d, required consecutive", a0, a1, a2);
    end
    n_checks++;
    if (mon_q.size() != 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d beats, required 3", mon_q.size());
    end else begin
      n_checks++;
      if (mon_q[0].port != 1 || mon_q[0].data !== 32'hC100_0000 || mon_q[0].last !== 1'b1 ||
          mon_q[1].port != 6 || mon_q[1].data !== 32'hC600_0000 || mon_q[1].cyc != a0 + 2 ||
          mon_q[2].port != 6 || mon_q[2].data !== 32'hC600_0001 || mon_q[2].cyc != a0 + 3) begin
        n_fail++;
        $display("FAIL b2b_order: got ports %0d %0d %0d cycs %0d %0d %0d, required 1 6 6 at %0d %0d %0d",
                 mon_q[0].port, mon_q[1].port, mon_q[2].port, mon_q[0].cyc, mon_q[1].cyc, mon_q[2].cyc,
                 a0 + 1, a0 + 2, a0 + 3);
      end
    end

    // Pending beat on out_1 must block the next packet's first beat.
    clear_mon();
    out_tready[1] = 1'b0;
    drive_beat(8'd129, 32'hC100_0001, 4'hF, 1'b1);
    bus_sel   = 8'd134;
    in_tvalid = 1'b1;
    in_tdata  = 32'hC600_0002;
    in_tlast  = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (in_tready !== 1'b0 || out_tvalid[1] !== 1'b1 || out_tvalid[6] !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_dest_hold[%0d]: got in_tready %b v1 %b v6 %b, required 0 1 0", c, in_tready, out_tvalid[1], out_tvalid[6]);
      end
      @(posedge clk);
      #1;
    end
    out_tready[1] = 1'b1;
    drive_beat(8'd134, 32'hC600_0002, 4'hF, 1'b0);
    drive_beat(8'd134, 32'hC600_0003, 4'hF, 1'b1);
    drain(4);
    n_checks++;
    if (mon_q.size() != 3) begin
      n_fail++;
      $display("FAIL b2b_switch_count: got %0d beats, required 3", mon_q.size());
    end else begin
      n_checks++;
      if (mon_q[0].port != 1 || mon_q[0].data !== 32'hC100_0001 ||
          mon_q[1].port != 6 || mon_q[1].data !== 32'hC600_0002 || mon_q[1].cyc != mon_q[0].cyc + 1 ||
          mon_q[2].port != 6 || mon_q[2].data !== 32'hC600_0003) begin
        n_fail++;
        $display("FAIL b2b_switch: got ports %0d %0d %0d data %h %h %h, required 1 6 6 C1000001 C6000002 C6000003",
                 mon_q[0].port, mon_q[1].port, mon_q[2].port, mon_q[0].data, mon_q[1].data, mon_q[2].data);
      end
    end
  endtask

  task automatic test_invalid_sel();
    out_tready = 8'hFF;
    clear_mon();
`ifdef AXIS_DEMUX_DROP_EN
    drive_beat(8'd5, 32'hE000_0000, 4'hF, 1'b0);
    drive_beat(8'd5, 32'hE000_0001, 4'hF, 1'b1);
    drain(3);
    n_checks++;
    if (mon_q.size() != 0) begin n_fail++; $display("FAIL drop_out_beats: got %0d, required 0", mon_q.size()); end
    for (int n = 0; n < 8; n++) begin
      n_checks++;
      if (vcnt[n] != 0) begin n_fail++; $display("FAIL drop_valid[%0d]: got %0d cycles, required 0", n, vcnt[n]); end
    end
    n_checks++;
    if (drop_cnt !== 16'd1) begin n_fail++; $display("FAIL drop_cnt: got %0d, required 1", drop_cnt); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy: got %b, required 0", busy); end
`else
    bus_sel   = 8'd5;
    in_tvalid = 1'b1;
    in_tdata  = 32'hE000_0000;
    in_tkeep  = 4'hF;
    in_tlast  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (in_tready !== 1'b0 || out_tvalid !== 8'h00 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL badsel_stall[%0d]: got in_tready %b tvalid %b busy %b, required 0 00000000 0", c, in_tready, out_tvalid, busy);
      end
      @(posedge clk);
      #1;
    end
    drive_beat(8'd128, 32'hE000_0000, 4'hF, 1'b0);
    drive_beat(8'd128, 32'hE000_0001, 4'hF, 1'b1);
    drain(4);
    n_checks++;
    if (mon_q.size() != 2) begin
      n_fail++;
      $display("FAIL badsel_count: got %0d beats, required 2", mon_q.size());
    end else begin
      n_checks++;
      if (mon_q[0].port != 0 || mon_q[0].data !== 32'hE000_0000 ||
          mon_q[1].port != 0 || mon_q[1].data !== 32'hE000_0001 || mon_q[1].last !== 1'b1) begin
        n_fail++;
        $display("FAIL badsel_route: got ports %0d %0d data %h %h, required 0 0 E0000000 E0000001",
                 mon_q[0].port, mon_q[1].port, mon_q[0].data, mon_q[1].data);
      end
    end
`endif
  endtask

  task automatic test_reset_midpkt();
    out_tready = 8'hFF;
    clear_mon();
    drive_beat(8'd133, 32'hF000_0000, 4'hF, 1'b0);
    in_tvalid = 1'b1;
    in_tdata  = 32'hF000_0001;
    in_tlast  = 1'b0;
    rstn      = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    in_idle();
    @(negedge clk);
    n_checks++;
    if (out_tvalid !== 8'h00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_clear: got tvalid %b busy %b, required 00000000 0", out_tvalid, busy);
    end
    @(posedge clk);
    #1;
    clear_mon();
    drive_beat(8'd132, 32'h4000_0000, 4'hF, 1'b0);
    drive_beat(8'd132, 32'h4000_0001, 4'hF, 1'b1);
    drain(4);
    n_checks++;
    if (mon_q.size() != 2) begin
      n_fail++;
      $display("FAIL rst_mid_count: got %0d beats, required 2", mon_q.size());
    end else begin
      n_checks++;
      if (mon_q[0].port != 4 || mon_q[0].data !== 32'h4000_0000 ||
          mon_q[1].port != 4 || mon_q[1].data !== 32'h4000_0001 || mon_q[1].last !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_mid_route: got ports %0d %0d data %h %h, required 4 4 40000000 40000001",
                 mon_q[0].port, mon_q[1].port, mon_q[0].data, mon_q[1].data);
      end
    end
    n_checks++;
    if (vcnt[5] != 0) begin n_fail++; $display("FAIL rst_mid_out5: got %0d valid cycles, required 0", vcnt[5]); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    acc_cyc  = 0;
    for (int n = 0; n < 8; n++) vcnt[n] = 0;
    test_reset();
    test_route_basic();
    test_sel_hold();
    test_backpressure();
    test_back_to_back();
    test_invalid_sel();
    test_reset_midpkt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
